// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared FSM state type, default phase lengths and level-fault decode
package irrigation_pkg;
  typedef enum logic [2:0] {IDLE, SPRINKLE, DRIP, COOLDOWN, ALARM} state_t;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_SPRINKLE_CYCLES = 1000;
  localparam int DEF_DRIP_CYCLES = 3000;
  localparam int DEF_COOLDOWN_CYCLES = 500;
  localparam int DEF_DISPLAY_CYCLES = 200;
  // A wet higher sensor above a dry lower one cannot be physical water.
  function automatic logic level_fault(input logic h, input logic m, input logic l);
    return (h & ~m) | (m & ~l);
  endfunction
endpackage

// File: rtl/irrigation_scheduler_debounce.sv
// sensor_debounce: 2-flop synchronizer plus hold-time filter for one sensor bit
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        dout <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: valve sequencing, inlet hysteresis, level alarm and display select
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int SPRINKLE_CYCLES = DEF_SPRINKLE_CYCLES,
  parameter int DRIP_CYCLES = DEF_DRIP_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int DISPLAY_CYCLES = DEF_DISPLAY_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic h,
  input  logic m,
  input  logic l,
  input  logic us,
  input  logic ua,
  input  logic t,
  output logic ve,
  output logic asp,
  output logic got,
  output logic alarme,
  output logic selector,
  output logic busy
);
  localparam int DW = $clog2(DISPLAY_CYCLES) + 1;
  logic [5:0] raw, deb;
  logic h_d, m_d, l_d, us_d, ua_d, t_d, fault;
  state_t state, next;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [DW-1:0] dcnt;
  assign raw = {h, m, l, us, ua, t};
  for (genvar i = 0; i < 6; i++) begin : g_deb
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk),
      .rst(rst),
      .din(raw[i]),
      .dout(deb[i])
    );
  end
  assign {h_d, m_d, l_d, us_d, ua_d, t_d} = deb;
  assign fault = level_fault(h_d, m_d, l_d);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= next;
      timer <= timer_nxt;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (~us_d & l_d) next = (t_d | ~ua_d | ~m_d) ? DRIP : SPRINKLE;
      SPRINKLE: if (timer == '0 || us_d || ~m_d) next = COOLDOWN;
      DRIP:     if (timer == '0 || us_d || ~l_d) next = COOLDOWN;
      COOLDOWN: if (timer == '0) next = IDLE;
      ALARM:    if (~alarme) next = COOLDOWN;
      default:  next = IDLE;
    endcase
    if (fault) next = ALARM;
    // Every phase entry reloads the shared timer; otherwise it counts down to 0.
    timer_nxt = (next != state) ?
                ((next == SPRINKLE) ? CNT_W'(SPRINKLE_CYCLES - 1) :
                 (next == DRIP)     ? CNT_W'(DRIP_CYCLES - 1) :
                 (next == COOLDOWN) ? CNT_W'(COOLDOWN_CYCLES - 1) : '0) :
                (timer == '0) ? '0 : timer - 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      asp <= 1'b0;
      got <= 1'b0;
      busy <= 1'b0;
    end else begin
      asp <= next == SPRINKLE;
      got <= next == DRIP;
      busy <= next inside {SPRINKLE, DRIP, COOLDOWN};
    end
  always_ff @(posedge clk)
    if (rst) begin
      ve <= 1'b0;
      alarme <= 1'b0;
    end else begin
      alarme <= fault;
      ve <= (next == ALARM || fault || h_d) ? 1'b0 : (~m_d ? 1'b1 : ve);
    end
  // Display view alternates freely, pinned to the level view during a fault.
  always_ff @(posedge clk)
    if (rst) begin
      selector <= 1'b0;
      dcnt <= '0;
    end else if (fault) begin
      selector <= 1'b1;
      dcnt <= '0;
    end else if (dcnt == DW'(DISPLAY_CYCLES - 1)) begin
      selector <= ~selector;
      dcnt <= '0;
    end else dcnt <= dcnt + 1'b1;
endmodule
